// File: rtl/icache_mem_adapter.sv
// icache line refill -> BEATS fetch reads, reassembles out-of-order beats into one line; optional ICACHE_MEM_ADAPTER_CRITICAL_WORD_FIRST_EN.
// Latency: first fetch read the cycle after txreq accept; line returned the cycle after the last beat lands.
// Backpressure: one line in flight; txreq_rdy only in IDLE, fetch addr/id and rxdat held until accepted.
module icache_mem_adapter #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_WIDTH       = 512,
  parameter int FETCH_DATA_WIDTH = 128,
  parameter int ENTRY_ID_WIDTH   = 5,
  parameter int MEM_ID_WIDTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 downstream_txreq_vld,
  output logic                                 downstream_txreq_rdy,
  input  logic [ADDR_WIDTH-1:0]                downstream_txreq_pld,
  input  logic [ENTRY_ID_WIDTH-1:0]            downstream_txreq_entry_id,
  output logic                                 downstream_rxdat_vld,
  input  logic                                 downstream_rxdat_rdy,
  output logic [ENTRY_ID_WIDTH+LINE_WIDTH-1:0] downstream_rxdat_pld,
  output logic                                 fetch_mem_req_vld,
  input  logic                                 fetch_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]                fetch_mem_req_addr,
  output logic [MEM_ID_WIDTH-1:0]              fetch_mem_req_entry_id,
  input  logic                                 fetch_mem_ack_vld,
  output logic                                 fetch_mem_ack_rdy,
  input  logic [FETCH_DATA_WIDTH-1:0]          fetch_mem_ack_data,
  input  logic [MEM_ID_WIDTH-1:0]              fetch_mem_ack_entry_id
);

  localparam int BEATS     = LINE_WIDTH / FETCH_DATA_WIDTH;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int LINE_OFF  = $clog2(LINE_WIDTH / 8);
  localparam int BEAT_OFF  = $clog2(FETCH_DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                                     state, state_nxt;
  logic [BEAT_BITS:0]                         issue_cnt, issue_cnt_nxt;
  logic [BEATS-1:0]                           mask, mask_nxt;
  logic [BEATS-1:0][FETCH_DATA_WIDTH-1:0]     line_q;
  logic [ADDR_WIDTH-1:0]                      line_base;
  logic [ENTRY_ID_WIDTH-1:0]                  entry_id_q;
  logic [BEAT_BITS-1:0]                       crit_q;
  logic [BEAT_BITS-1:0]                       beat;
  logic [BEAT_BITS-1:0]                       ack_slot;
  logic                                       txreq_fire, req_fire, ack_fire;
  logic                                       all_issued, all_acked;

  // Handshakes decoded from state so the FSM block has no combinational feedback.
  assign txreq_fire = (state == IDLE) && downstream_txreq_vld;
  assign req_fire   = (state == REQ) && fetch_mem_req_rdy;
  assign ack_fire   = ((state == REQ) || (state == WAIT)) && fetch_mem_ack_vld;
  assign ack_slot   = fetch_mem_ack_entry_id[BEAT_BITS-1:0];

  assign issue_cnt_nxt = issue_cnt + (BEAT_BITS+1)'(req_fire);
  assign mask_nxt      = mask | (ack_fire ? (BEATS'(1) << ack_slot) : '0);
  assign all_issued    = (issue_cnt_nxt == (BEAT_BITS+1)'(BEATS));
  assign all_acked     = &mask_nxt;

  // Issue order rotates from the critical beat; ids and placement stay absolute.
  assign beat                   = crit_q + issue_cnt[BEAT_BITS-1:0];
  assign fetch_mem_req_addr     = line_base + (ADDR_WIDTH'(beat) << BEAT_OFF);
  assign fetch_mem_req_entry_id = MEM_ID_WIDTH'(beat);
  assign downstream_rxdat_pld   = {entry_id_q, line_q};

`ifdef ICACHE_MEM_ADAPTER_CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      crit_q <= '0;
    end else if (txreq_fire) begin
      crit_q <= downstream_txreq_pld[LINE_OFF-1:BEAT_OFF];
    end
  end
`else
  assign crit_q = '0;
`endif

  if (MEM_ID_WIDTH > BEAT_BITS) begin : g_id_hi
    logic unused_id_hi;
    assign unused_id_hi = ^fetch_mem_ack_entry_id[MEM_ID_WIDTH-1:BEAT_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    downstream_txreq_rdy = 1'b0;
    downstream_rxdat_vld = 1'b0;
    fetch_mem_req_vld    = 1'b0;
    fetch_mem_ack_rdy    = 1'b0;
    case (state)
      IDLE: begin
        downstream_txreq_rdy = 1'b1;
        if (downstream_txreq_vld) state_nxt = REQ;
      end
      REQ: begin
        fetch_mem_req_vld = 1'b1;
        fetch_mem_ack_rdy = 1'b1;
        if (all_issued) state_nxt = all_acked ? RESP : WAIT;
      end
      WAIT: begin
        fetch_mem_ack_rdy = 1'b1;
        if (all_acked) state_nxt = RESP;
      end
      RESP: begin
        downstream_rxdat_vld = 1'b1;
        if (downstream_rxdat_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      issue_cnt  <= '0;
      mask       <= '0;
      line_q     <= '0;
      line_base  <= '0;
      entry_id_q <= '0;
    end else begin
      if (txreq_fire) begin
        line_base  <= downstream_txreq_pld & ~ADDR_WIDTH'((1 << LINE_OFF) - 1);
        entry_id_q <= downstream_txreq_entry_id;
        issue_cnt  <= '0;
        mask       <= '0;
      end else begin
        issue_cnt <= issue_cnt_nxt;
        mask      <= mask_nxt;
      end
      // Duplicate acks simply overwrite their slot.
      if (ack_fire) line_q[ack_slot] <= fetch_mem_ack_data;
    end
  end

endmodule

// File: tb/tb_icache_mem_adapter.sv
// Self-checking bench: randomized memory responder plus a line-level reference model.
module tb_icache_mem_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         downstream_txreq_vld, downstream_txreq_rdy;
  logic [31:0]  downstream_txreq_pld;
  logic [4:0]   downstream_txreq_entry_id;
  logic         downstream_rxdat_vld, downstream_rxdat_rdy;
  logic [516:0] downstream_rxdat_pld;
  logic         fetch_mem_req_vld, fetch_mem_req_rdy;
  logic [31:0]  fetch_mem_req_addr;
  logic [3:0]   fetch_mem_req_entry_id;
  logic         fetch_mem_ack_vld, fetch_mem_ack_rdy;
  logic [127:0] fetch_mem_ack_data;
  logic [3:0]   fetch_mem_ack_entry_id;

  icache_mem_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .downstream_txreq_vld(downstream_txreq_vld), .downstream_txreq_rdy(downstream_txreq_rdy),
    .downstream_txreq_pld(downstream_txreq_pld), .downstream_txreq_entry_id(downstream_txreq_entry_id),
    .downstream_rxdat_vld(downstream_rxdat_vld), .downstream_rxdat_rdy(downstream_rxdat_rdy),
    .downstream_rxdat_pld(downstream_rxdat_pld),
    .fetch_mem_req_vld(fetch_mem_req_vld), .fetch_mem_req_rdy(fetch_mem_req_rdy),
    .fetch_mem_req_addr(fetch_mem_req_addr), .fetch_mem_req_entry_id(fetch_mem_req_entry_id),
    .fetch_mem_ack_vld(fetch_mem_ack_vld), .fetch_mem_ack_rdy(fetch_mem_ack_rdy),
    .fetch_mem_ack_data(fetch_mem_ack_data), .fetch_mem_ack_entry_id(fetch_mem_ack_entry_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory responder knobs and logs
  int           req_rdy_pct = 100;
  bit           req_stall   = 0;
  int           ack_mode    = 0;   // 0 in-order, 1 random order/gaps, 2 scripted
  int           ack_cnt     = 0;
  int           ack_sel     = 0;
  logic [3:0]   script_id[$];
  logic [127:0] script_dat[$];
  logic [31:0]  pend_addr[$];
  logic [3:0]   pend_id[$];
  logic [31:0]  seen_addr[$];
  logic [3:0]   seen_id[$];

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + 32'h1111_1111, ~a, a};
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFC0;
  endfunction

  function automatic int exp_beat(input logic [31:0] req, input int k);
    int crit;
    crit = 0;
`ifdef ICACHE_MEM_ADAPTER_CRITICAL_WORD_FIRST_EN
    crit = int'(req[5:4]);
`endif
    return (crit + k) % 4;
  endfunction

  function automatic logic [516:0] exp_line(input logic [31:0] req, input logic [4:0] id);
    logic [511:0] l;
    for (int k = 0; k < 4; k++) l[k*128 +: 128] = mem_word(line_of(req) + 32'(k * 16));
    return {id, l};
  endfunction

  initial begin
    bit ack_taken, rst_seen;
    fetch_mem_req_rdy = 0; fetch_mem_ack_vld = 0;
    fetch_mem_ack_data = '0; fetch_mem_ack_entry_id = '0;
    forever begin
      @(negedge clk);
      rst_seen  = rst_n;
      ack_taken = fetch_mem_ack_vld && fetch_mem_ack_rdy && !rst_n;
      if (!rst_n && fetch_mem_req_vld && fetch_mem_req_rdy) begin
        seen_addr.push_back(fetch_mem_req_addr); seen_id.push_back(fetch_mem_req_entry_id);
        pend_addr.push_back(fetch_mem_req_addr); pend_id.push_back(fetch_mem_req_entry_id);
      end
      if (ack_taken) ack_cnt++;
      @(posedge clk); #1;
      if (rst_seen) begin
        pend_addr.delete(); pend_id.delete(); fetch_mem_ack_vld = 0;
      end else if (ack_taken) begin
        fetch_mem_ack_vld = 0;
        if (ack_mode == 2) begin
          void'(script_id.pop_front()); void'(script_dat.pop_front());
          if (script_id.size() == 0) begin pend_addr.delete(); pend_id.delete(); end
        end else begin
          pend_addr.delete(ack_sel); pend_id.delete(ack_sel);
        end
      end
      fetch_mem_req_rdy = !req_stall && ($urandom_range(99) < req_rdy_pct);
      if (!fetch_mem_ack_vld && !rst_seen) begin
        if (ack_mode == 2) begin
          if (pend_addr.size() >= 4 && script_id.size() > 0) begin
            fetch_mem_ack_vld = 1; fetch_mem_ack_entry_id = script_id[0]; fetch_mem_ack_data = script_dat[0];
          end
        end else if (pend_addr.size() > 0 && (ack_mode == 0 || $urandom_range(1) == 1)) begin
          ack_sel = (ack_mode == 0) ? 0 : int'($urandom_range(pend_addr.size() - 1));
          fetch_mem_ack_vld  = 1;
          fetch_mem_ack_data = mem_word(pend_addr[ack_sel]);
          fetch_mem_ack_entry_id = (ack_mode == 0) ? pend_id[ack_sel]
                                 : {2'($urandom_range(3)), pend_id[ack_sel][1:0]};
        end
      end
    end
  end

  // Drive one txreq until accepted; ok=0 if never accepted.
  task automatic drive_txreq(input logic [31:0] a, input logic [4:0] id, output bit ok);
    ok = 0;
    downstream_txreq_vld = 1; downstream_txreq_pld = a; downstream_txreq_entry_id = id;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (downstream_txreq_rdy) ok = 1;
      @(posedge clk); #1;
    end
    downstream_txreq_vld = 0; downstream_txreq_pld = $urandom; downstream_txreq_entry_id = 5'($urandom);
  endtask

  task automatic collect_line(input int stall, output logic [516:0] pld, output bit ok);
    int n;
    n = 0; ok = 0; pld = '0;
    while (!downstream_rxdat_vld && n < 2000) begin @(posedge clk); #1; n++; end
    if (downstream_rxdat_vld) begin
      repeat (stall) begin @(posedge clk); #1; end
      pld = downstream_rxdat_pld;
      downstream_rxdat_rdy = 1;
      @(posedge clk); #1;
      downstream_rxdat_rdy = 0;
      ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1; downstream_txreq_vld = 0; downstream_rxdat_rdy = 0;
    downstream_txreq_pld = '0; downstream_txreq_entry_id = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (fetch_mem_req_vld !== 1'b0) begin errors++; $display("FAIL reset_req_vld: got %b want 0", fetch_mem_req_vld); end
    checks++; if (downstream_rxdat_vld !== 1'b0) begin errors++; $display("FAIL reset_rxdat_vld: got %b want 0", downstream_rxdat_vld); end
    checks++; if (fetch_mem_ack_rdy !== 1'b0) begin errors++; $display("FAIL reset_ack_rdy: got %b want 0", fetch_mem_ack_rdy); end
    checks++; if (downstream_rxdat_pld !== 517'd0) begin errors++; $display("FAIL reset_pld: got %h want 0", downstream_rxdat_pld); end
    rst_n = 0;
    @(posedge clk); #1;
    checks++; if (downstream_txreq_rdy !== 1'b1) begin errors++; $display("FAIL reset_txreq_rdy: got %b want 1", downstream_txreq_rdy); end
  endtask

  task automatic test_basic();
    bit ok; logic [516:0] pld; logic [31:0] a;
    a = 32'h0000_1234;
    req_rdy_pct = 100; ack_mode = 0; seen_addr.delete(); seen_id.delete();
    drive_txreq(a, 5'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept: got not accepted want accepted"); end
    checks++; if (fetch_mem_req_vld !== 1'b1 || downstream_txreq_rdy !== 1'b0)
      begin errors++; $display("FAIL basic_first_req: got vld=%b txrdy=%b want vld=1 txrdy=0", fetch_mem_req_vld, downstream_txreq_rdy); end
    collect_line(0, pld, ok);
    checks++; if (!ok || pld !== exp_line(a, 5'd5)) begin errors++; $display("FAIL basic_line: got %h want %h", pld, exp_line(a, 5'd5)); end
    checks++; if (seen_addr.size() != 4) begin errors++; $display("FAIL basic_req_count: got %0d want 4", seen_addr.size()); end
    for (int k = 0; k < 4 && k < seen_addr.size(); k++) begin
      checks++;
      if (seen_addr[k] !== line_of(a) + 32'(exp_beat(a, k) * 16) || seen_id[k] !== 4'(exp_beat(a, k)))
        begin errors++; $display("FAIL basic_req%0d: got %h/%0d want %h/%0d", k, seen_addr[k], seen_id[k], line_of(a) + 32'(exp_beat(a, k) * 16), exp_beat(a, k)); end
    end
  endtask

  task automatic test_out_of_order();
    bit ok; logic [516:0] pld, exp; int start, n;
    ack_mode = 2; start = ack_cnt;
    script_id  = '{4'd2, 4'd0, 4'd3, 4'd1};
    script_dat = '{128'hA, 128'hB, 128'hC, 128'hD};
    exp = {5'd9, 128'hC, 128'hA, 128'hD, 128'hB};
    drive_txreq(32'h0000_5A40, 5'd9, ok);
    n = 0;
    while (!downstream_rxdat_vld && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (!downstream_rxdat_vld || ack_cnt - start != 4)
      begin errors++; $display("FAIL ooo_vld_after_4th: got vld=%b acks=%0d want vld=1 acks=4", downstream_rxdat_vld, ack_cnt - start); end
    collect_line(0, pld, ok);
    checks++; if (!ok || pld !== exp) begin errors++; $display("FAIL ooo_line: got %h want %h", pld, exp); end
    ack_mode = 0;
  endtask

  task automatic test_stalls();
    bit ok; logic [516:0] pld, first; logic [31:0] a, a0; int n;
    a = 32'h0000_3B7C; seen_addr.delete(); seen_id.delete();
    a0 = line_of(a) + 32'(exp_beat(a, 0) * 16);
    req_stall = 1;
    drive_txreq(a, 5'd17, ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_mem_req_vld !== 1'b1 || fetch_mem_req_addr !== a0 || fetch_mem_req_entry_id !== 4'(exp_beat(a, 0)))
        begin errors++; $display("FAIL stall_req_hold%0d: got %b %h %0d want 1 %h %0d", i, fetch_mem_req_vld, fetch_mem_req_addr, fetch_mem_req_entry_id, a0, exp_beat(a, 0)); end
      @(posedge clk); #1;
    end
    req_stall = 0;
    n = 0;
    while (!downstream_rxdat_vld && n < 200) begin @(posedge clk); #1; n++; end
    first = downstream_rxdat_pld;
    downstream_txreq_vld = 1; downstream_txreq_pld = 32'h0000_7000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (downstream_rxdat_vld !== 1'b1 || downstream_rxdat_pld !== exp_line(a, 5'd17) || downstream_txreq_rdy !== 1'b0)
        begin errors++; $display("FAIL stall_rx_hold%0d: got vld=%b txrdy=%b pld=%h want 1 0 %h", i, downstream_rxdat_vld, downstream_txreq_rdy, downstream_rxdat_pld, exp_line(a, 5'd17)); end
      @(posedge clk); #1;
    end
    downstream_txreq_vld = 0;
    collect_line(0, pld, ok);
    checks++; if (!ok || pld !== first) begin errors++; $display("FAIL stall_line: got %h want %h", pld, first); end
    checks++; if (seen_addr.size() != 4) begin errors++; $display("FAIL stall_req_count: got %0d want 4", seen_addr.size()); end
    for (int k = 0; k < 4 && k < seen_addr.size(); k++) begin
      checks++;
      if (seen_addr[k] !== line_of(a) + 32'(exp_beat(a, k) * 16))
        begin errors++; $display("FAIL stall_req%0d: got %h want %h", k, seen_addr[k], line_of(a) + 32'(exp_beat(a, k) * 16)); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [516:0] pld1, pld2; logic [31:0] a1, a2; int n;
    a1 = 32'h0000_1040; a2 = 32'h0000_2008;
    seen_addr.delete(); seen_id.delete();
    drive_txreq(a1, 5'd1, ok);
    downstream_txreq_vld = 1; downstream_txreq_pld = a2; downstream_txreq_entry_id = 5'd2;
    n = 0;
    while (!downstream_rxdat_vld && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (downstream_rxdat_vld !== 1'b1 || downstream_txreq_rdy !== 1'b0)
      begin errors++; $display("FAIL b2b_resp: got vld=%b txrdy=%b want 1 0", downstream_rxdat_vld, downstream_txreq_rdy); end
    pld1 = downstream_rxdat_pld;
    downstream_rxdat_rdy = 1;
    @(posedge clk); #1;
    downstream_rxdat_rdy = 0;
    checks++; if (downstream_txreq_rdy !== 1'b1 || downstream_rxdat_vld !== 1'b0)
      begin errors++; $display("FAIL b2b_idle: got txrdy=%b vld=%b want 1 0", downstream_txreq_rdy, downstream_rxdat_vld); end
    @(posedge clk); #1;
    checks++; if (fetch_mem_req_vld !== 1'b1 || downstream_txreq_rdy !== 1'b0)
      begin errors++; $display("FAIL b2b_second_accept: got reqvld=%b txrdy=%b want 1 0", fetch_mem_req_vld, downstream_txreq_rdy); end
    downstream_txreq_vld = 0;
    collect_line(0, pld2, ok);
    checks++; if (pld1 !== exp_line(a1, 5'd1)) begin errors++; $display("FAIL b2b_line1: got %h want %h", pld1, exp_line(a1, 5'd1)); end
    checks++; if (!ok || pld2 !== exp_line(a2, 5'd2)) begin errors++; $display("FAIL b2b_line2: got %h want %h", pld2, exp_line(a2, 5'd2)); end
    checks++; if (seen_addr.size() != 8 || seen_addr[4] !== line_of(a2) + 32'(exp_beat(a2, 0) * 16))
      begin errors++; $display("FAIL b2b_reqs: got %0d reqs want 8 with line2 first at %h", seen_addr.size(), line_of(a2) + 32'(exp_beat(a2, 0) * 16)); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [516:0] pld; logic [31:0] a; int n;
    ack_mode = 0; req_rdy_pct = 100; seen_addr.delete(); seen_id.delete();
    drive_txreq(32'h0000_4400, 5'd3, ok);
    n = 0;
    while (seen_addr.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    rst_n = 1; ack_mode = 2;
    @(posedge clk); #1;
    rst_n = 0;
    checks++; if (fetch_mem_req_vld !== 1'b0 || downstream_rxdat_vld !== 1'b0 || fetch_mem_ack_rdy !== 1'b0 || downstream_txreq_rdy !== 1'b1)
      begin errors++; $display("FAIL midrst_outputs: got req=%b rx=%b ackrdy=%b txrdy=%b want 0 0 0 1", fetch_mem_req_vld, downstream_rxdat_vld, fetch_mem_ack_rdy, downstream_txreq_rdy); end
    @(posedge clk); #1;
    // Reverse-order acks: stale mask bits would complete the line early with old data.
    a = 32'h0000_6610;
    script_id.delete(); script_dat.delete();
    for (int k = 3; k >= 0; k--) begin
      script_id.push_back(4'(k)); script_dat.push_back(mem_word(line_of(a) + 32'(k * 16)));
    end
    seen_addr.delete(); seen_id.delete();
    drive_txreq(a, 5'd30, ok);
    collect_line(0, pld, ok);
    checks++; if (!ok || pld !== exp_line(a, 5'd30)) begin errors++; $display("FAIL midrst_line: got %h want %h", pld, exp_line(a, 5'd30)); end
    ack_mode = 0;
  endtask

  task automatic test_random();
    bit ok; logic [516:0] pld; logic [31:0] a; logic [4:0] id;
    ack_mode = 1; req_rdy_pct = 60;
    for (int i = 0; i < 12; i++) begin
      a  = (i == 0) ? 32'hFFFF_FFF8 : $urandom;
      id = 5'($urandom);
      seen_addr.delete(); seen_id.delete();
      drive_txreq(a, id, ok);
      collect_line(int'($urandom_range(3)), pld, ok);
      checks++; if (!ok || pld !== exp_line(a, id)) begin errors++; $display("FAIL rand_line%0d: got %h want %h", i, pld, exp_line(a, id)); end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (k >= seen_addr.size() || seen_addr[k] !== line_of(a) + 32'(exp_beat(a, k) * 16))
          begin errors++; $display("FAIL rand_req%0d_%0d: got %0d reqs want addr %h", i, k, seen_addr.size(), line_of(a) + 32'(exp_beat(a, k) * 16)); end
      end
    end
    ack_mode = 0; req_rdy_pct = 100;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_out_of_order();
    test_stalls();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_mem_adapter.md
Name: icache_mem_adapter

Overview:
- Bridges the icache refill port (downstream_txreq / downstream_rxdat) to the instruction-memory fetch bus (fetch_mem_req / fetch_mem_ack).
- Each accepted line request is split into BEATS sequential fetch reads, tagged by beat index.
- Returned beats, possibly out of order, are assembled into one cache line.
- The full line is returned to the icache with its original entry id. One line is in flight at a time.

Parameters:
- ADDR_WIDTH, 32: address width.
- LINE_WIDTH, 512: cache line width in bits.
- FETCH_DATA_WIDTH, 128: fetch beat width in bits. BEATS = LINE_WIDTH/FETCH_DATA_WIDTH = 4; must be a power of 2, at least 2.
- ENTRY_ID_WIDTH, 5: width of the icache refill entry id.
- MEM_ID_WIDTH, 4: width of the fetch entry id. Must be at least log2(BEATS).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous reset. Active-HIGH despite the codebase name: 1 = reset.
- downstream_txreq_vld  in  1  line refill request valid.
- downstream_txreq_rdy  out  1  request accepted.
- downstream_txreq_pld  in  ADDR_WIDTH  request byte address (any byte in the line).
- downstream_txreq_entry_id  in  ENTRY_ID_WIDTH  icache MSHR entry id.
- downstream_rxdat_vld  out  1  refill line valid.
- downstream_rxdat_rdy  in  1  icache accepts the line.
- downstream_rxdat_pld  out  ENTRY_ID_WIDTH+LINE_WIDTH  {entry_id, line}; beat 0 sits in the LSBs of line.
- fetch_mem_req_vld  out  1  memory read valid.
- fetch_mem_req_rdy  in  1  memory accepts the read.
- fetch_mem_req_addr  out  ADDR_WIDTH  beat byte address.
- fetch_mem_req_entry_id  out  MEM_ID_WIDTH  beat index, zero-extended.
- fetch_mem_ack_vld  in  1  memory data valid.
- fetch_mem_ack_rdy  out  1  adapter accepts data.
- fetch_mem_ack_data  in  FETCH_DATA_WIDTH  beat data.
- fetch_mem_ack_entry_id  in  MEM_ID_WIDTH  beat index of the returned data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset: while rst_n=1, FSM goes to IDLE; issue counter, beat-valid mask, line buffer, latched address and latched id are all cleared.
- Reset outputs: all vld outputs = 0; fetch_mem_ack_rdy = 0; downstream_rxdat_pld = 0; downstream_txreq_rdy = 1 from the first cycle after reset.
- Reset mid-transaction discards the transaction. Acks from memory arriving after reset are not accepted until a new line is in flight.

- IDLE:
  - txreq_rdy = 1.
  - On txreq vld&rdy: latch line_base = pld with the low log2(LINE_WIDTH/8) bits cleared; latch entry_id; clear mask and counter; go to REQ.
- REQ:
  - fetch_mem_req_vld = 1.
  - addr = line_base + beat*(FETCH_DATA_WIDTH/8); entry_id = beat, where beat = issue counter, beat order 0,1,…,BEATS-1.
  - Addr/id are held stable while rdy = 0.
  - Counter increments on vld&rdy. After the BEATS-th handshake, go to WAIT.
  - First fetch_mem_req_vld is asserted the cycle after txreq acceptance.
- REQ and WAIT:
  - fetch_mem_ack_rdy = 1.
  - On ack vld&rdy: write data into line slot ack_entry_id[log2(BEATS)-1:0] and set that mask bit.
  - Upper id bits are ignored.
  - A duplicate ack overwrites the slot.
- Completion: when the mask is all ones (counting an ack in the current cycle) and all beats have been issued, go to RESP on the next edge.
  - This applies from REQ or WAIT, including when the last issue and last ack occur in the same cycle.
- RESP:
  - rxdat_vld = 1 with pld = {entry_id, line}, held stable until rdy.
  - On vld&rdy, go to IDLE.
  - txreq_rdy = 0 and ack_rdy = 0 in RESP.
  - No same-cycle bypass: the next txreq can be accepted no earlier than the cycle after the rxdat handshake.
- txreq_rdy = 0 in REQ, WAIT and RESP.
- Address arithmetic is modulo 2^ADDR_WIDTH; a line at the top of the address space wraps.
- Minimum latency with memory that is always ready and zero-wait: txreq accept at T, reqs at T+1..T+BEATS.

Optional Feature:
- Macro: ICACHE_MEM_ADAPTER_CRITICAL_WORD_FIRST_EN.
- When defined:
  - The first beat issued is the beat containing the original request address: crit = pld bits [log2(LINE_WIDTH/8)-1 : log2(FETCH_DATA_WIDTH/8)].
  - Issue order is crit, crit+1, … modulo BEATS, wrapping at the line end.
  - fetch_mem_req_entry_id and placement still use the absolute beat index, so the assembled line is identical.
- When undefined: crit = 0, giving the order 0..BEATS-1.

Test Plan:
- Basic line fill: memory always ready, in-order 1-cycle acks. Send txreq pld=0x0000_1234, id=5.
  - Reqs go to 0x1200, 0x1210, 0x1220, 0x1230 with ids 0..3.
  - rxdat pld = {5, beat3..beat0}, and the line matches memory.
- Out-of-order acks with ids 2, 0, 3, 1 and data 0xA..0xD: line slot k holds the data for id k; rxdat is asserted only after the 4th ack.
- Stalls:
  - Hold fetch_mem_req_rdy = 0 for 3 cycles: addr/id stay stable and no beat is skipped.
  - Hold rxdat_rdy = 0 for 5 cycles: vld and pld stay stable, and txreq_rdy stays 0 until the handshake.
- Back-to-back requests: id=1 then id=2 (line 0x2000). Second txreq is accepted the cycle after the first rxdat handshake, with no data mixing between the lines.
- Reset mid-operation:
  - Assert rst_n after 2 beats issued: all vld = 0 next cycle and txreq_rdy = 1.
  - A new line fills correctly with no stale mask bits.
- Critical-word-first with the macro defined: pld = 0x1234 (crit = 3). Issue order is 0x1230, 0x1200, 0x1210, 0x1220 and the line is identical to the basic test.
